// File: rtl/box_sprite_renderer.sv
// Colours each pixel of the 96x64 OLED frame with a movable square sprite
// (outline + fill) over a flat background; the sprite is stepped by buttons at frame start.
module box_sprite_renderer #(
  parameter int          BOX_SIZE    = 8,
  parameter int          STEP_DIV    = 2,
  parameter logic [15:0] BG_COLOUR   = 16'h0000,
  parameter logic [15:0] FILL_COLOUR = 16'hF800,
  parameter logic [15:0] EDGE_COLOUR = 16'h07E0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [15:0] oled_data,
  output logic [7:0]  box_x,
  output logic [6:0]  box_y,
  output logic        moving
);

  localparam logic [7:0] X_MAX    = 8'(96 - BOX_SIZE);
  localparam logic [6:0] Y_MAX    = 7'(64 - BOX_SIZE);
  localparam logic [7:0] X_INIT   = 8'((96 - BOX_SIZE) / 2);
  localparam logic [6:0] Y_INIT   = 7'((64 - BOX_SIZE) / 2);
  localparam logic [7:0] BS_M1    = 8'(BOX_SIZE - 1);
  localparam logic [3:0] CNT_LAST = 4'(STEP_DIV - 1);

  typedef enum logic {S_IDLE, S_MOVE} state_t;
  typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  state_t      r_state, w_state_n;
  dir_t        r_dir, w_dir_n, w_sel;
  logic [3:0]  r_cnt, w_cnt_n;
  logic [7:0]  r_box_x, w_box_x_n;
  logic [6:0]  r_box_y, w_box_y_n;
  logic [15:0] r_oled, w_colour;
  logic        w_step;

  always_comb begin
    w_sel = D_NONE;
    if      (btn_up)    w_sel = D_UP;
    else if (btn_down)  w_sel = D_DOWN;
    else if (btn_left)  w_sel = D_LEFT;
    else if (btn_right) w_sel = D_RIGHT;
  end

  // The counter only advances while the same direction is held across frames;
  // entering MOVE or changing direction restarts it without stepping.
  always_comb begin
    w_state_n = r_state;
    w_dir_n   = r_dir;
    w_cnt_n   = r_cnt;
    w_step    = 1'b0;
    if (frame_begin) begin
      case (r_state)
        S_IDLE: if (w_sel != D_NONE) begin
          w_state_n = S_MOVE;
          w_dir_n   = w_sel;
          w_cnt_n   = '0;
        end
        S_MOVE: begin
          if (w_sel == D_NONE) begin
            w_state_n = S_IDLE;
            w_dir_n   = D_NONE;
            w_cnt_n   = '0;
          end else if (w_sel != r_dir) begin
            w_dir_n = w_sel;
            w_cnt_n = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_step  = 1'b1;
            w_cnt_n = '0;
          end else begin
            w_cnt_n = r_cnt + 4'd1;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Steps at a limit hold the position; the FSM stays in MOVE.
  always_comb begin
    w_box_x_n = r_box_x;
    w_box_y_n = r_box_y;
    if (w_step) begin
      case (r_dir)
        D_UP:    if (r_box_y != 7'd0)  w_box_y_n = r_box_y - 7'd1;
        D_DOWN:  if (r_box_y <  Y_MAX) w_box_y_n = r_box_y + 7'd1;
        D_LEFT:  if (r_box_x != 8'd0)  w_box_x_n = r_box_x - 8'd1;
        D_RIGHT: if (r_box_x <  X_MAX) w_box_x_n = r_box_x + 8'd1;
        default: ;
      endcase
    end
  end

  logic [7:0] w_y8, w_by8, w_x_hi, w_y_hi;
  logic       w_in_range, w_inside, w_edge;

  always_comb begin
    w_y8       = {1'b0, y};
    w_by8      = {1'b0, r_box_y};
    w_x_hi     = r_box_x + BS_M1;
    w_y_hi     = w_by8 + BS_M1;
    w_in_range = (x < 8'd96) && (w_y8 < 8'd64);
    w_inside   = w_in_range && (x >= r_box_x) && (x <= w_x_hi) &&
                 (w_y8 >= w_by8) && (w_y8 <= w_y_hi);
    w_edge     = w_inside && ((x == r_box_x) || (x == w_x_hi) ||
                              (w_y8 == w_by8) || (w_y8 == w_y_hi));
    w_colour   = BG_COLOUR;
    if (w_edge)        w_colour = EDGE_COLOUR;
    else if (w_inside) w_colour = FILL_COLOUR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= D_NONE;
      r_cnt   <= '0;
      r_box_x <= X_INIT;
      r_box_y <= Y_INIT;
      r_oled  <= BG_COLOUR;
    end else begin
      r_state <= w_state_n;
      r_dir   <= w_dir_n;
      r_cnt   <= w_cnt_n;
      r_box_x <= w_box_x_n;
      r_box_y <= w_box_y_n;
      r_oled  <= w_colour;
    end
  end

  assign oled_data = r_oled;
  assign box_x     = r_box_x;
  assign box_y     = r_box_y;
  assign moving    = (r_state == S_MOVE);

endmodule

// File: tb/tb_box_sprite_renderer.sv
// Randomised bench for box_sprite_renderer against a frame-level model of the
// sprite position and a geometric pixel-colour reference.
module tb_box_sprite_renderer;
  localparam int BS = 8;
  localparam int SD = 2;
  localparam logic [15:0] BG = 16'h0000, FILL = 16'hF800, EDGE = 16'h07E0;

  logic        clk = 1'b0, rst_n = 1'b0, frame_begin = 1'b0;
  logic [7:0]  x = '0;
  logic [6:0]  y = '0;
  logic        bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic [15:0] oled_data;
  logic [7:0]  box_x;
  logic [6:0]  box_y;
  logic        moving;

  box_sprite_renderer dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .x(x), .y(y),
    .btn_up(bu), .btn_down(bd), .btn_left(bl), .btn_right(br),
    .oled_data(oled_data), .box_x(box_x), .box_y(box_y), .moving(moving)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  int m_bx, m_by, m_dir, m_cnt;
  bit m_mov;

  function automatic logic [15:0] ref_col(input int px, input int py, input int bx, input int by);
    if (px >= 96 || py >= 64) return BG;
    if (px < bx || px > bx + BS - 1 || py < by || py > by + BS - 1) return BG;
    if (px == bx || px == bx + BS - 1 || py == by || py == by + BS - 1) return EDGE;
    return FILL;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic model_reset;
    m_bx = (96 - BS) / 2; m_by = (64 - BS) / 2;
    m_dir = 0; m_cnt = 0; m_mov = 1'b0;
  endtask

  // dir codes: 0 none, 1 up, 2 down, 3 left, 4 right
  task automatic model_frame(input bit u, input bit d, input bit l, input bit r);
    int sel;
    sel = u ? 1 : d ? 2 : l ? 3 : r ? 4 : 0;
    if (!m_mov) begin
      if (sel != 0) begin m_mov = 1'b1; m_dir = sel; m_cnt = 0; end
    end else if (sel == 0) begin
      m_mov = 1'b0; m_dir = 0; m_cnt = 0;
    end else if (sel != m_dir) begin
      m_dir = sel; m_cnt = 0;
    end else if (m_cnt == SD - 1) begin
      m_cnt = 0;
      case (m_dir)
        1: if (m_by > 0) m_by--;
        2: if (m_by < 64 - BS) m_by++;
        3: if (m_bx > 0) m_bx--;
        4: if (m_bx < 96 - BS) m_bx++;
        default: ;
      endcase
    end else begin
      m_cnt++;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; frame_begin = 1'b0; {bu, bd, bl, br} = '0; x = '0; y = '0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    model_reset;
  endtask

  task automatic frame(input bit u, input bit d, input bit l, input bit r);
    {bu, bd, bl, br} = {u, d, l, r};
    frame_begin = 1'b1;
    tick;
    frame_begin = 1'b0;
    model_frame(u, d, l, r);
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    x = 8'd44; y = 7'd28;
    tick;
    checks++; if (box_x !== 8'd44) $display("FAIL reset_box_x: got %0d want 44", box_x); else passed++;
    checks++; if (box_y !== 7'd28) $display("FAIL reset_box_y: got %0d want 28", box_y); else passed++;
    checks++; if (moving !== 1'b0) $display("FAIL reset_moving: got %b want 0", moving); else passed++;
    checks++; if (oled_data !== BG) $display("FAIL reset_oled: got %h want %h", oled_data, BG); else passed++;
    rst_n = 1'b1;
    model_reset;
    x = 8'd44; y = 7'd28; tick;
    checks++; if (oled_data !== 16'h07E0) $display("FAIL pix_corner: got %h want 07e0", oled_data); else passed++;
    x = 8'd46; y = 7'd30; tick;
    checks++; if (oled_data !== 16'hF800) $display("FAIL pix_fill: got %h want f800", oled_data); else passed++;
    x = 8'd0; y = 7'd0; tick;
    checks++; if (oled_data !== 16'h0000) $display("FAIL pix_bg: got %h want 0000", oled_data); else passed++;
    x = 8'd100; y = 7'd10; tick;
    checks++; if (oled_data !== 16'h0000) $display("FAIL pix_oor: got %h want 0000", oled_data); else passed++;
    x = 8'd51; y = 7'd35; tick;
    checks++; if (oled_data !== 16'h07E0) $display("FAIL pix_far_corner: got %h want 07e0", oled_data); else passed++;
  endtask

  task automatic test_pixels_random;
    int px, py;
    logic [15:0] exp;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        px = $urandom_range(0, 255); py = $urandom_range(0, 127);
      end else begin
        px = m_bx - 2 + $urandom_range(0, BS + 3);
        py = m_by - 2 + $urandom_range(0, BS + 3);
      end
      exp = ref_col(px, py, m_bx, m_by);
      x = 8'(px); y = 7'(py);
      tick;
      checks++; if (oled_data !== exp) $display("FAIL pix_rand: x=%0d y=%0d got %h want %h", px, py, oled_data, exp); else passed++;
    end
  endtask

  task automatic test_move_right;
    int exp_bx[6] = '{44, 44, 45, 45, 46, 46};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      frame(0, 0, 0, 1);
      checks++; if (box_x !== 8'(exp_bx[i]) || box_x !== 8'(m_bx)) $display("FAIL right_box_x: pulse %0d got %0d want %0d", i + 1, box_x, exp_bx[i]); else passed++;
      checks++; if (moving !== 1'b1 || box_y !== 7'd28) $display("FAIL right_state: pulse %0d moving=%b box_y=%0d want 1/28", i + 1, moving, box_y); else passed++;
    end
  endtask

  task automatic test_clamp_left;
    do_reset;
    for (int i = 0; i < 100; i++) frame(0, 0, 1, 0);
    checks++; if (box_x !== 8'd0 || m_bx != 0) $display("FAIL left_reach0: got %0d want 0", box_x); else passed++;
    for (int i = 0; i < 10; i++) begin
      frame(0, 0, 1, 0);
      checks++; if (box_x !== 8'd0 || moving !== 1'b1) $display("FAIL left_clamp: got box_x=%0d moving=%b want 0/1", box_x, moving); else passed++;
    end
    frame(0, 0, 0, 0);
    checks++; if (moving !== 1'b0 || box_x !== 8'd0) $display("FAIL left_release: got moving=%b box_x=%0d want 0/0", moving, box_x); else passed++;
  endtask

  task automatic test_priority_switch;
    int exp_by[6] = '{28, 28, 27, 27, 27, 28};
    do_reset;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) frame(1, 0, 0, 1); else frame(0, 1, 0, 0);
      checks++; if (box_y !== 7'(exp_by[i]) || box_y !== 7'(m_by)) $display("FAIL prio_box_y: pulse %0d got %0d want %0d", i + 1, box_y, exp_by[i]); else passed++;
      checks++; if (box_x !== 8'd44) $display("FAIL prio_box_x: pulse %0d got %0d want 44", i + 1, box_x); else passed++;
    end
  endtask

  task automatic test_toggle_between;
    do_reset;
    for (int i = 0; i < 20; i++) begin
      {bu, bd, bl, br} = 4'($urandom_range(1, 15)); tick;
    end
    checks++; if (moving !== 1'b0 || box_x !== 8'd44 || box_y !== 7'd28) $display("FAIL toggle_idle: got %b/%0d/%0d want 0/44/28", moving, box_x, box_y); else passed++;
    frame(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      {bu, bd, bl, br} = 4'($urandom_range(0, 15)); tick;
    end
    checks++; if (moving !== 1'b1 || box_x !== 8'(m_bx) || box_y !== 7'(m_by)) $display("FAIL toggle_move: got %b/%0d/%0d want 1/%0d/%0d", moving, box_x, box_y, m_bx, m_by); else passed++;
  endtask

  task automatic test_random;
    logic [3:0] b;
    logic [15:0] exp;
    int px, py;
    do_reset;
    b = '0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) b = 4'($urandom_range(0, 15));
      px = m_bx - 1 + $urandom_range(0, BS + 1);
      py = m_by - 1 + $urandom_range(0, BS + 1);
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      exp = ref_col(px, py, m_bx, m_by);
      x = 8'(px); y = 7'(py);
      {bu, bd, bl, br} = b;
      frame_begin = 1'b1;
      tick;
      frame_begin = 1'b0;
      checks++; if (oled_data !== exp) $display("FAIL rand_oled_oldpos: x=%0d y=%0d got %h want %h", px, py, oled_data, exp); else passed++;
      model_frame(b[3], b[2], b[1], b[0]);
      checks++; if (box_x !== 8'(m_bx) || box_y !== 7'(m_by) || moving !== m_mov) $display("FAIL rand_state: got %0d/%0d/%b want %0d/%0d/%b", box_x, box_y, moving, m_bx, m_by, m_mov); else passed++;
      tick;
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    for (int i = 0; i < 3; i++) frame(0, 0, 0, 1);
    x = 8'd45; y = 7'd28; tick;
    checks++; if (oled_data !== EDGE || moving !== 1'b1 || box_x !== 8'd45) $display("FAIL pre_async: got %h/%b/%0d want %h/1/45", oled_data, moving, box_x, EDGE); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (box_x !== 8'd44 || box_y !== 7'd28) $display("FAIL async_pos: got %0d/%0d want 44/28", box_x, box_y); else passed++;
    checks++; if (moving !== 1'b0 || oled_data !== BG) $display("FAIL async_out: got %b/%h want 0/%h", moving, oled_data, BG); else passed++;
    tick;
    rst_n = 1'b1;
    model_reset;
    {bu, bd, bl, br} = '0;
    frame(0, 0, 0, 1);
    checks++; if (box_x !== 8'd44 || moving !== 1'b1) $display("FAIL after_async: got %0d/%b want 44/1", box_x, moving); else passed++;
  endtask

  initial begin
    test_reset;
    test_pixels_random;
    test_move_right;
    test_pixels_random;
    test_clamp_left;
    test_pixels_random;
    test_priority_switch;
    test_toggle_between;
    test_random;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
